// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Walks a program counter through instruction memory on behalf of a host.
// The host launches a program by raising start and then dropping it. The
// first fetch is at START_ADDR in the cycle after start falls. From then on
// every unstalled cycle retires one instruction, which does one of three
// things:
//   - steps the PC by one,
//   - branches (absolute, or relative with a signed 8-bit offset), or
//   - halts, which raises ack until the host launches again.
//
// Handshake: start is a level request, not valid/ready. Raising start in
// IDLE or DONE arms the sequencer and reloads pc/icount. Dropping start
// while armed begins execution. start is ignored while running and while
// reset is high.
//
// Ports
//   clk        in   1     rising-edge clock
//   reset      in   1     asynchronous active-high reset
//   start      in   1     launch request from the host
//   stall      in   1     freeze pc/icount/state this cycle (RUN only)
//   halt       in   1     halt instruction at current pc
//   br_en      in   1     taken branch at current pc
//   br_rel     in   1     1 = pc-relative (offset in br_target[7:0]), 0 = absolute
//   br_target  in   PC_W  branch target or signed offset
//   pc         out  PC_W  instruction memory address
//   run        out  1     high while fetching (registered)
//   ack        out  1     program complete (registered)
//   icount     out  16    instructions retired since launch, saturating
//   dbg_state  out  2     current FSM state, for checkers/debug
//
// PC_W must be at least 8 so the relative offset fits in the PC width.

module fetch_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt,
  input  logic            br_en,
  input  logic            br_rel,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic            run,
  output logic            ack,
  output logic [15:0]     icount,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     icount_q, icount_d;
  logic            run_q, run_d;
  logic            ack_q, ack_d;

  // Datapath helpers. Every PC sum is truncated to PC_W bits, which gives
  // the required modulo-2^PC_W wrap in both directions.
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_rel;
  logic [15:0]     icount_inc;

  // Sign-extend the 8-bit relative offset to the PC width.
  assign br_offset  = PC_W'($signed(br_target[7:0]));
  assign pc_seq     = pc_q + PC_W'(1);
  assign pc_rel     = pc_q + br_offset;
  // The retire counter sticks at all-ones rather than wrapping.
  assign icount_inc = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;

  // Next-state and next-value logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARMED;
          pc_d     = START_ADDR;
          icount_d = 16'd0;
        end
      end

      ARMED: begin
        // Stay armed for as long as the host holds start high.
        if (!start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // A stall freezes everything, so halt and branch are not looked at.
        // Otherwise exactly one instruction retires, and halt takes priority
        // over branch.
        if (!stall) begin
          icount_d = icount_inc;
          if (halt) begin
            state_d = DONE;
          end else if (br_en) begin
            pc_d = br_rel ? pc_rel : br_target;
          end else begin
            pc_d = pc_seq;
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d  = ARMED;
          pc_d     = START_ADDR;
          icount_d = 16'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are decoded from the next state so that they change on
    // the same edge as the state does, straight out of flops.
    run_d = (state_d == RUN);
    ack_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= START_ADDR;
      icount_q <= 16'd0;
      run_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      run_q    <= run_d;
      ack_q    <= ack_d;
    end
  end

  assign pc        = pc_q;
  assign run       = run_q;
  assign ack       = ack_q;
  assign icount    = icount_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int PC_W = 10;
  localparam int AMAX = 1 << PC_W;
  localparam int EW   = PC_W + 2 + 16;

  // Clock and reset
  logic            clk = 1'b0;
  logic            reset;
  logic            start, stall, halt, br_en, br_rel;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc;
  logic            run, ack;
  logic [15:0]     icount;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PC_W), .START_ADDR('0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .br_en(br_en), .br_rel(br_rel), .br_target(br_target),
    .pc(pc), .run(run), .ack(ack), .icount(icount), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Vector table
  typedef struct {
    string           name;
    logic            start, stall, halt, br_en, br_rel;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc;
    logic            run, ack;
    logic [15:0]     ic;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string nm, input logic s, input logic st,
                              input logic h, input logic be, input logic br,
                              input int t, input int p, input logic r,
                              input logic a, input int ic);
    vec_t v;
    v.name = nm; v.start = s; v.stall = st; v.halt = h; v.br_en = be;
    v.br_rel = br; v.tgt = PC_W'(t); v.pc = PC_W'(p); v.run = r; v.ack = a;
    v.ic = 16'(ic);
    vecs.push_back(v);
  endfunction

  // Driver tasks
  task automatic drive(input logic s, input logic st, input logic h,
                       input logic be, input logic br, input logic [PC_W-1:0] t);
    start = s; stall = st; halt = h; br_en = be; br_rel = br; br_target = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [PC_W-1:0] e_pc,
                       input logic e_run, input logic e_ack, input logic [15:0] e_ic);
    n_vec++;
    if (pc !== e_pc || run !== e_run || ack !== e_ack || icount !== e_ic) begin
      n_err++;
      $display("FAIL %s: got pc=%0d run=%0b ack=%0b icount=%0d, want pc=%0d run=%0b ack=%0b icount=%0d",
               name, pc, run, ack, icount, e_pc, e_run, e_ack, e_ic);
    end
  endtask

  // Reference model: the program as the host sees it, with int arithmetic
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
  int m_state, m_pc, m_ic;

  function automatic void model_reset();
    m_state = M_IDLE; m_pc = 0; m_ic = 0;
  endfunction

  function automatic void model_step(input logic s, input logic st, input logic h,
                                     input logic be, input logic br, input int t);
    int off;
    if ((m_state == M_IDLE || m_state == M_DONE) && s) begin
      m_state = M_ARMED; m_pc = 0; m_ic = 0;
    end else if (m_state == M_ARMED && !s) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN && !st) begin
      if (m_ic < 65535) m_ic = m_ic + 1;
      if (h) begin
        m_state = M_DONE;
      end else if (be && br) begin
        off = t % 256;
        if (off >= 128) off = off - 256;
        m_pc = ((m_pc + off) % AMAX + AMAX) % AMAX;
      end else if (be) begin
        m_pc = t;
      end else begin
        m_pc = (m_pc + 1) % AMAX;
      end
    end
  endfunction

  function automatic logic [EW-1:0] model_exp();
    return {PC_W'(m_pc), (m_state == M_RUN), (m_state == M_DONE), 16'(m_ic)};
  endfunction

  // Scoreboard
  logic [EW-1:0] exp_q[$];

  task automatic check_sb(input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e[EW-1 -: PC_W], e[17], e[16], e[15:0]);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Reset with start held high; the outputs are forced without a clock
    reset = 1'b1;
    #2;
    check("reset_async", '0, 1'b0, 1'b0, 16'd0);
    step();
    check("reset_holds_start", '0, 1'b0, 1'b0, 16'd0);
    #2 reset = 1'b0;
    #1;

    // Table: launch, run, halt, relaunch, branches, wrap, halt priority
    add("arm",          1,0,0,0,0,   0,    0, 0,0, 0);
    add("run_entry",    0,0,0,0,0,   0,    0, 1,0, 0);
    for (int i = 1; i <= 7; i++)
      add($sformatf("free_%0d", i), 0,0,0,0,0, 0, i, 1,0, i);
    add("halt",         0,0,1,0,0,   0,    7, 0,1, 8);
    add("done_hold",    0,0,0,0,0,   0,    7, 0,1, 8);
    add("done_start1",  1,0,0,0,0,   0,    0, 0,0, 0);
    add("done_start2",  1,0,0,0,0,   0,    0, 0,0, 0);
    add("rerun",        0,0,0,0,0,   0,    0, 1,0, 0);
    add("br_abs20",     0,0,0,1,0,  20,   20, 1,0, 1);
    add("br_rel_m5",    0,0,0,1,1, 'h0FB, 15, 1,0, 2);
    add("br_abs300",    0,0,0,1,0, 300,  300, 1,0, 3);
    add("br_self",      0,0,0,1,1,   0,  300, 1,0, 4);
    add("stall_hold",   0,1,1,1,0,   5,  300, 1,0, 4);
    add("br_abs_max",   0,0,0,1,0, 1023, 1023, 1,0, 5);
    add("wrap_up",      0,0,0,0,0,   0,    0, 1,0, 6);
    add("wrap_down",    0,0,0,1,1, 'h0FB, 1019, 1,0, 7);
    add("br_abs_max2",  0,0,0,1,0, 1023, 1023, 1,0, 8);
    add("wrap_up2",     0,0,0,0,0,   0,    0, 1,0, 9);
    add("stall_halt",   0,1,1,0,0,   0,    0, 1,0, 9);
    add("halt_and_br",  0,0,1,1,0,   5,    0, 0,1, 10);
    add("done_ign_br",  0,0,0,1,0,   5,    0, 0,1, 10);
    add("relaunch",     1,0,0,0,0,   0,    0, 0,0, 0);
    add("run_again",    0,0,0,0,0,   0,    0, 1,0, 0);
    add("start_in_run", 1,0,0,0,0,   0,    1, 1,0, 1);
    add("start_in_run2",1,0,0,0,0,   0,    2, 1,0, 2);
    add("start_drop",   0,0,0,0,0,   0,    3, 1,0, 3);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].br_en,
            vecs[i].br_rel, vecs[i].tgt);
      step();
      check(vecs[i].name, vecs[i].pc, vecs[i].run, vecs[i].ack, vecs[i].ic);
    end

    // Advance to pc=9, then reset between edges
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 4; i <= 9; i++) begin
      step();
      check($sformatf("to_pc9_%0d", i), PC_W'(i), 1'b1, 1'b0, 16'(i));
    end
    #2 reset = 1'b1;
    #1 check("reset_mid_run", '0, 1'b0, 1'b0, 16'd0);
    start = 1'b1;
    step();
    check("reset_ign_start", '0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("idle_no_start", '0, 1'b0, 1'b0, 16'd0);

    // icount saturation
    start = 1'b1;
    step();
    check("sat_arm", '0, 1'b0, 1'b0, 16'd0);
    start = 1'b0;
    step();
    check("sat_run", '0, 1'b1, 1'b0, 16'd0);
    repeat (65535) @(posedge clk);
    #1 check("sat_reach", PC_W'(1023), 1'b1, 1'b0, 16'hFFFF);
    step();
    check("sat_hold", '0, 1'b1, 1'b0, 16'hFFFF);
    step();
    check("sat_hold2", PC_W'(1), 1'b1, 1'b0, 16'hFFFF);

    // Randomized run against the reference model
    #2 reset = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_exp());
    check_sb("rnd_reset");
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        exp_q.push_back(model_exp());
        check_sb("rnd_async_reset");
        start = 1'($urandom_range(0, 1));
        step();
        exp_q.push_back(model_exp());
        check_sb("rnd_reset_held");
        reset = 1'b0;
      end else begin
        drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 1)), PC_W'($urandom_range(0, AMAX - 1)));
        model_step(start, stall, halt, br_en, br_rel, int'(br_target));
        exp_q.push_back(model_exp());
        step();
        check_sb("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL take parameter PC_W, default 10, as the program counter width in bits.
REQ-002 The block SHALL take parameter START_ADDR, default 0, as the program counter value loaded at reset and on each launch.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  launch request from the host.
REQ-007 stall  input  1  holds the current PC and count for this cycle.
REQ-008 halt  input  1  decoded halt instruction at the current PC.
REQ-009 br_en  input  1  taken branch at the current PC.
REQ-010 br_rel  input  1  1 means PC-relative branch, 0 means absolute branch.
REQ-011 br_target  input  PC_W  absolute target, or signed offset in bits [7:0] when br_rel=1.
REQ-012 pc  output  PC_W  instruction memory address.
REQ-013 run  output  1  high while instructions are being fetched.
REQ-014 ack  output  1  program-complete flag to the host.
REQ-015 icount  output  16  count of instructions retired since the last launch.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ARMED, RUN, DONE.
REQ-017 IDLE with start=1 SHALL go to ARMED and load pc=START_ADDR and icount=0.
REQ-018 ARMED SHALL stay in ARMED while start=1 and go to RUN on the first edge with start=0.
- Launch is start-high-then-low.
- The first fetch is at START_ADDR in the cycle after start falls.
REQ-019 In RUN with stall=1, the block SHALL hold pc, icount and state, and ignore halt and br_en.
REQ-020 In RUN with stall=0, the block SHALL apply the first matching rule:
- halt=1: go to DONE, pc held, icount+1.
- br_en=1, br_rel=0: pc=br_target, icount+1.
- br_en=1, br_rel=1: pc=pc + sign-extended br_target[7:0], icount+1.
- otherwise: pc=pc+1, icount+1.
REQ-021 PC arithmetic SHALL be modulo 2^PC_W.
- Max address +1 wraps to 0.
- A negative offset below 0 wraps to the top of the address space.
REQ-022 icount SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-023 run SHALL be 1 only in RUN, registered.
REQ-024 ack SHALL be 1 only in DONE, registered.
- ack rises on the edge that takes halt.
REQ-025 DONE SHALL hold pc and icount.
- start=1 in DONE goes to ARMED, clears ack on that edge, reloads pc=START_ADDR and clears icount.
REQ-026 start SHALL be ignored in RUN; a start pulse mid-program does not restart it.
REQ-027 halt and br_en both asserted in the same cycle SHALL resolve as halt.
REQ-028 br_en=1 with br_rel=1 and offset 0 SHALL keep the same pc and still count an instruction (self-loop).

Reset
REQ-029 Asserting reset SHALL, immediately and without waiting for clk, force:
- state=IDLE, pc=START_ADDR, run=0, ack=0, icount=0.
REQ-030 While reset=1, start SHALL be ignored.
- A start held high through reset deassertion is seen as an IDLE->ARMED request on the first clk edge after reset falls.
REQ-031 Reset asserted in any state, including mid-RUN or DONE, SHALL abort the program with the REQ-029 values.

Verification
REQ-032 Reset with start high, release both, then 5 free cycles:
- pc goes 0,1,2,3,4,5; run=1; ack=0; icount=5.
REQ-033 In RUN at pc=7, apply halt with stall=0:
- next edge gives ack=1, run=0, pc=7, icount=8.
- further cycles hold all values.
REQ-034 At pc=20, apply br_rel=1 with br_target[7:0]=8'hFB (-5):
- pc=15.
- then br_rel=0 with br_target=300 gives pc=300.
REQ-035 Default PC_W, pc=1023, no branch:
- pc wraps to 0.
- halt together with stall=1: no transition.
- next cycle, halt and br_en together with stall=0: DONE, pc held.
REQ-036 In RUN at pc=9, assert reset between clock edges:
- pc=0, run=0, ack=0 before the next edge.
- a start pulse given in RUN beforehand leaves the program unaffected.
REQ-037 In DONE, pulse start for 2 cycles then drop it:
- ack=0 on the first edge.
- pc=0 and icount=0.
- RUN is entered on the edge where start=0.
